mulalu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the MIPS datapath. It consumes the `mulalu_func`/`mulalu_sign` request and operands produced alongside the single-cycle ALU. It computes MULT/MULTU in 2 cycles and DIV/DIVU in 33 cycles. It stalls the pipeline while busy and issues one HI/LO write pulse on completion.

---
 rtl/mulalu.sv | 170 +++++++++++++++++
 tb/tb_mulalu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mulalu.sv
// mulalu: multi-cycle MULT/MULTU (2 cycles) and DIV/DIVU (33 cycles) unit
// for the EX stage; stalls the pipe while busy, pulses HI/LO write once.
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   func, sign              request (FUNC_MUL / FUNC_DIV / 0) and signedness
//   source_a, source_b      multiplicand/dividend, multiplier/divisor
//   ex_advance, flush       EX register load, abort
//   stall                   combinational pipeline hold
//   hi_write(_data)         HI strobe and value (high product / remainder)
//   lo_write(_data)         LO strobe and value (low product / quotient)
module mulalu (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  func,
    input  logic        sign,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    input  logic        ex_advance,
    input  logic        flush,
    output logic        stall,
    output logic        hi_write,
    output logic [31:0] hi_write_data,
    output logic        lo_write,
    output logic [31:0] lo_write_data
);

    localparam logic [4:0] FUNC_MUL = 5'b00001;
    localparam logic [4:0] FUNC_DIV = 5'b00010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rem;
    logic        op_sign;
    logic        q_sign;
    logic        r_sign;

    // multiply: 33-bit extended operands, low 64 bits of the product
    logic [32:0]        mul_a;
    logic [32:0]        mul_b;
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic signed [63:0] prod;

    assign mul_a = {op_sign & op_a[31], op_a};
    assign mul_b = {op_sign & op_b[31], op_b};
    assign ext_a = {{31{mul_a[32]}}, mul_a};
    assign ext_b = {{31{mul_b[32]}}, mul_b};
    assign prod  = ext_a * ext_b;

    // restoring divide step; op_a shifts out dividend bits, shifts in quotient
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    assign shifted  = {rem, op_a[31]};
    assign ge       = shifted >= {1'b0, op_b};
    assign diff     = shifted[31:0] - op_b;
    assign rem_next = ge ? diff : shifted[31:0];
    assign quo_next = {op_a[30:0], ge};
    assign quo_fin  = q_sign ? -quo_next : quo_next;
    assign rem_fin  = r_sign ? -rem_next : rem_next;

    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign a_mag = (sign && source_a[31]) ? -source_a : source_a;
    assign b_mag = (sign && source_b[31]) ? -source_b : source_b;

    always_comb begin
        stall = 1'b0;
        if (resetn && !flush) begin
            unique case (state)
                S_IDLE:  stall = (func != 5'b00000);
                S_MUL:   stall = 1'b1;
                S_DIV:   stall = 1'b1;
                S_DONE:  stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            cnt           <= 5'd0;
            op_a          <= 32'd0;
            op_b          <= 32'd0;
            rem           <= 32'd0;
            op_sign       <= 1'b0;
            q_sign        <= 1'b0;
            r_sign        <= 1'b0;
            hi_write      <= 1'b0;
            lo_write      <= 1'b0;
            hi_write_data <= 32'd0;
            lo_write_data <= 32'd0;
        end else begin
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (func == FUNC_MUL) begin
                            op_a    <= source_a;
                            op_b    <= source_b;
                            op_sign <= sign;
                            state   <= S_MUL;
                        end else if (func == FUNC_DIV) begin
                            cnt <= 5'd0;
                            rem <= 32'd0;
                            op_b <= b_mag;
                            if (source_b == 32'd0) begin
                                // divisor 0: every step subtracts nothing, so
                                // the raw dividend lands in rem and the
                                // quotient fills with ones; no sign fix-up
                                op_a   <= source_a;
                                q_sign <= 1'b0;
                                r_sign <= 1'b0;
                            end else begin
                                op_a   <= a_mag;
                                q_sign <= sign & (source_a[31] ^ source_b[31]);
                                r_sign <= sign & source_a[31];
                            end
                            state <= S_DIV;
                        end
                    end
                    S_MUL: begin
                        hi_write_data <= prod[63:32];
                        lo_write_data <= prod[31:0];
                        hi_write      <= 1'b1;
                        lo_write      <= 1'b1;
                        state         <= S_DONE;
                    end
                    S_DIV: begin
                        op_a <= quo_next;
                        rem  <= rem_next;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hi_write_data <= rem_fin;
                            lo_write_data <= quo_fin;
                            hi_write      <= 1'b1;
                            lo_write      <= 1'b1;
                            state         <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (ex_advance) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mulalu.sv
// tb_mulalu: directed scoreboard bench for mulalu.
// Stimulus pushes expected {hi,lo}; the monitor pops on each write strobe.
module tb_mulalu;

    localparam logic [4:0] FUNC_MUL = 5'b00001;
    localparam logic [4:0] FUNC_DIV = 5'b00010;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  func;
    logic        sign;
    logic [31:0] source_a;
    logic [31:0] source_b;
    logic        ex_advance;
    logic        flush;
    logic        stall;
    logic        hi_write;
    logic [31:0] hi_write_data;
    logic        lo_write;
    logic [31:0] lo_write_data;

    mulalu dut (
        .clk           (clk),
        .resetn        (resetn),
        .func          (func),
        .sign          (sign),
        .source_a      (source_a),
        .source_b      (source_b),
        .ex_advance    (ex_advance),
        .flush         (flush),
        .stall         (stall),
        .hi_write      (hi_write),
        .hi_write_data (hi_write_data),
        .lo_write      (lo_write),
        .lo_write_data (lo_write_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          strobe_cnt = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && (hi_write || lo_write)) begin
            logic [63:0] e;
            strobe_cnt++;
            check("strobe_pair", {31'd0, hi_write}, {31'd0, lo_write});
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got hi=%h lo=%h expected none",
                         hi_write_data, lo_write_data);
            end else begin
                e = exp_q.pop_front();
                check("hi_data", hi_write_data, e[63:32]);
                check("lo_data", lo_write_data, e[31:0]);
            end
        end
    end

    task automatic issue(input logic [4:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int exp_stall, input int hold);
        int n;
        int sc0;
        @(negedge clk);
        func = f;
        sign = s;
        source_a = a;
        source_b = b;
        exp_q.push_back({eh, el});
        sc0 = strobe_cnt;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, exp_stall);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check("done_hold_hi", hi_write_data, eh);
            check("done_hold_lo", lo_write_data, el);
        end
        ex_advance = 1'b1;
        @(negedge clk);
        ex_advance = 1'b0;
        func = 5'b00000;
        repeat (2) @(negedge clk);
        check("strobe_count", strobe_cnt - sc0, 1);
    endtask

    task automatic abort_div(input logic use_reset);
        int sc0;
        @(negedge clk);
        func = FUNC_DIV;
        sign = 1'b1;
        source_a = 32'hFFFF_FFF9;
        source_b = 32'd2;
        sc0 = strobe_cnt;
        repeat (10) @(negedge clk);
        if (use_reset) begin
            resetn = 1'b0;
            #1;
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_hi_write", {31'd0, hi_write}, 32'd0);
            check("rst_lo_write", {31'd0, lo_write}, 32'd0);
            check("rst_hi_data", hi_write_data, 32'd0);
            check("rst_lo_data", lo_write_data, 32'd0);
            @(negedge clk);
            resetn = 1'b1;
        end else begin
            flush = 1'b1;
            #1;
            check("flush_stall", {31'd0, stall}, 32'd0);
            @(negedge clk);
            flush = 1'b0;
        end
        func = 5'b00000;
        #1;
        check("abort_idle_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_strobe", strobe_cnt - sc0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        func = 5'b00000;
        sign = 1'b0;
        source_a = 32'd0;
        source_b = 32'd0;
        ex_advance = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_hi_write", {31'd0, hi_write}, 32'd0);
        check("reset_lo_write", {31'd0, lo_write}, 32'd0);
        check("reset_hi_data", hi_write_data, 32'd0);
        check("reset_lo_data", lo_write_data, 32'd0);
        resetn = 1'b1;

        issue(FUNC_MUL, 1'b1, 32'hFFFF_FFFE, 32'd3,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 0);
        issue(FUNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 2, 0);
        issue(FUNC_MUL, 1'b1, 32'd7, 32'hFFFF_FFFB,
              32'hFFFF_FFFF, 32'hFFFF_FFDD, 2, 0);
        issue(FUNC_MUL, 1'b0, 32'h8000_0000, 32'd2,
              32'h0000_0001, 32'h0000_0000, 2, 0);
        issue(FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
        issue(FUNC_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2,
              32'h0000_0001, 32'h7FFF_FFFC, 33, 0);
        issue(FUNC_DIV, 1'b1, 32'hFFFF_FFF9, 32'd0,
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 0);
        issue(FUNC_DIV, 1'b0, 32'h1234_5678, 32'd0,
              32'h1234_5678, 32'hFFFF_FFFF, 33, 0);
        issue(FUNC_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 33, 0);
        issue(FUNC_DIV, 1'b1, 32'd100, 32'hFFFF_FFF9,
              32'h0000_0002, 32'hFFFF_FFF2, 33, 5);

        abort_div(1'b0);
        issue(FUNC_MUL, 1'b0, 32'd6, 32'd7,
              32'h0000_0000, 32'h0000_002A, 2, 0);
        abort_div(1'b1);
        issue(FUNC_DIV, 1'b0, 32'd45, 32'd7,
              32'h0000_0003, 32'h0000_0006, 33, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
